// File: rtl/lut_writer_pkg.sv
// Shared types and sizing helpers for the run-time loadable LUT-neuron table.
package lut_writer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no valid table
        LOAD  = 2'd1,   // accepting config beats
        READY = 2'd2    // table valid, lookups answered
    } state_e;

    // Table entries packed into one config word.
    function automatic int calc_epw(input int word_w, input int out_bits);
        return word_w / out_bits;
    endfunction

    // Config words needed to cover the whole table.
    function automatic int calc_num_words(input int in_bits, input int out_bits, input int word_w);
        return (1 << in_bits) / calc_epw(word_w, out_bits);
    endfunction

    // Counter/address width for n words, never below one bit.
    function automatic int calc_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_table_ram.sv
// Distributed RAM holding the truth table as whole config words; the read
// port returns one table entry, registered, and holds it between reads.
module lut_table_ram
    import lut_writer_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int WORD_W   = 32
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    wr_en,
    input  logic [calc_cnt_w(calc_num_words(IN_BITS, OUT_BITS, WORD_W))-1:0] wr_addr,
    input  logic [WORD_W-1:0]                                       wr_data,
    input  logic                                                    rd_en,
    input  logic [IN_BITS-1:0]                                      rd_addr,
    output logic [OUT_BITS-1:0]                                     rd_data
);

    localparam int EPW       = calc_epw(WORD_W, OUT_BITS);
    localparam int NUM_WORDS = calc_num_words(IN_BITS, OUT_BITS, WORD_W);
    localparam int ADDR_W    = calc_cnt_w(NUM_WORDS);

    (* ram_style = "distributed" *) logic [WORD_W-1:0] mem [NUM_WORDS];

    logic [ADDR_W-1:0]   rd_word;
    logic [31:0]         rd_slot;
    logic [OUT_BITS-1:0] rd_data_q;

    // EPW always divides the table depth, so these reduce to bit slicing.
    always_comb begin
        rd_word = ADDR_W'(32'(rd_addr) / EPW);
        rd_slot = 32'(rd_addr) % EPW;
    end

    // Write port: whole config word per accepted beat; contents never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: select the entry's slot, hold the last value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_word][rd_slot*OUT_BITS +: OUT_BITS];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/lut_table_writer.sv
// Loads a LUT-neuron truth table from a config word stream, then answers
// single-cycle-latency lookups from it. Framing errors leave the table invalid.
module lut_table_writer
    import lut_writer_pkg::*;
#(
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int WORD_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                cfg_last,
    output logic                cfg_done,
    output logic                cfg_err,
    input  logic [IN_BITS-1:0]  lut_in,
    input  logic                lut_in_valid,
    output logic [OUT_BITS-1:0] lut_out,
    output logic                lut_out_valid
);

    localparam int NUM_WORDS = calc_num_words(IN_BITS, OUT_BITS, WORD_W);
    localparam int CNT_W     = calc_cnt_w(NUM_WORDS);

    if ((WORD_W % OUT_BITS) != 0 || (((1 << IN_BITS) * OUT_BITS) % WORD_W) != 0) begin : g_param_check
        $error("lut_table_writer: WORD_W must be a multiple of OUT_BITS and divide the table size");
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic               cfg_err_q, cfg_err_d;
    logic               cfg_done_q, cfg_done_d;
    logic               lut_out_valid_q, lut_out_valid_d;

    logic               accept;
    logic               lookup_fire;
    logic               last_word;

    // A start pulse pre-empts any beat offered in the same cycle.
    assign cfg_ready   = (state_q == LOAD) && !cfg_start;
    assign accept      = cfg_valid && cfg_ready;
    // Lookups are served only from a complete table; one issued alongside a
    // start in READY still reads the old contents.
    assign lookup_fire = (state_q == READY) && lut_in_valid;
    assign last_word   = (wcnt_q == CNT_W'(NUM_WORDS - 1));

    // Next-state: load sequencing, framing checks and lookup handshake.
    always_comb begin
        state_d         = state_q;
        wcnt_d          = wcnt_q;
        cfg_err_d       = cfg_err_q;
        cfg_done_d      = 1'b0;
        lut_out_valid_d = lookup_fire;
        if (cfg_start) begin
            state_d   = LOAD;
            wcnt_d    = '0;
            cfg_err_d = 1'b0;
        end else if (accept) begin
            wcnt_d = wcnt_q + CNT_W'(1);
            if (last_word && cfg_last) begin
                state_d    = READY;
                cfg_done_d = 1'b1;
            end else if (last_word || cfg_last) begin
                // Too many or too few beats: beat is written but table stays invalid.
                state_d   = IDLE;
                cfg_err_d = 1'b1;
            end
        end
    end

    // FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            wcnt_q          <= '0;
            cfg_err_q       <= 1'b0;
            cfg_done_q      <= 1'b0;
            lut_out_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            wcnt_q          <= wcnt_d;
            cfg_err_q       <= cfg_err_d;
            cfg_done_q      <= cfg_done_d;
            lut_out_valid_q <= lut_out_valid_d;
        end
    end

    lut_table_ram #(
        .IN_BITS  (IN_BITS),
        .OUT_BITS (OUT_BITS),
        .WORD_W   (WORD_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wcnt_q),
        .wr_data (cfg_data),
        .rd_en   (lookup_fire),
        .rd_addr (lut_in),
        .rd_data (lut_out)
    );

    assign cfg_done      = cfg_done_q;
    assign cfg_err       = cfg_err_q;
    assign lut_out_valid = lut_out_valid_q;

endmodule

// File: tb/tb_lut_table_writer.sv
// Randomized bench for lut_table_writer against a table-level reference model.
module tb_lut_table_writer;

    localparam int EPW = 32;
    localparam int NW  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start, cfg_valid, cfg_last, lut_in_valid;
    logic        cfg_ready, cfg_done, cfg_err, lut_out_valid;
    logic [31:0] cfg_data;
    logic [7:0]  lut_in;
    logic [0:0]  lut_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: table words as written, whether a load is in progress,
    // whether the table is complete, and the expected registered outputs.
    logic [31:0] m_mem [NW];
    bit          m_loading, m_valid, m_err, m_done, m_out_valid;
    logic [0:0]  m_out;
    int          m_cnt;
    logic [31:0] ld_words [NW];

    always #5 clk = ~clk;

    lut_table_writer dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_start     (cfg_start),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_data      (cfg_data),
        .cfg_last      (cfg_last),
        .cfg_done      (cfg_done),
        .cfg_err       (cfg_err),
        .lut_in        (lut_in),
        .lut_in_valid  (lut_in_valid),
        .lut_out       (lut_out),
        .lut_out_valid (lut_out_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One clock: drive inputs, check handshake, clock, advance model, check outputs.
    task automatic cycle(input logic st, input logic v, input logic [31:0] d, input logic l,
                         input logic iv, input logic [7:0] a, input logic r);
        rst = r; cfg_start = st; cfg_valid = v; cfg_data = d; cfg_last = l;
        lut_in_valid = iv; lut_in = a;
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(m_loading && !st));
        @(posedge clk);
        if (r) begin
            m_loading = 0; m_valid = 0; m_cnt = 0; m_err = 0; m_done = 0;
            m_out_valid = 0; m_out = '0;
        end else begin
            m_out_valid = iv && m_valid;
            if (iv && m_valid) m_out = m_mem[int'(a) / EPW][int'(a) % EPW];
            m_done = 0;
            if (st) begin
                m_loading = 1; m_valid = 0; m_cnt = 0; m_err = 0;
            end else if (m_loading && v) begin
                m_mem[m_cnt] = d;
                if (m_cnt == NW - 1) begin
                    m_loading = 0;
                    if (l) begin m_valid = 1; m_done = 1; end
                    else m_err = 1;
                end else if (l) begin
                    m_loading = 0; m_err = 1;
                end else begin
                    m_cnt++;
                end
            end
        end
        #1;
        check("cfg_done", 32'(cfg_done), 32'(m_done));
        check("cfg_err", 32'(cfg_err), 32'(m_err));
        check("lut_out_valid", 32'(lut_out_valid), 32'(m_out_valid));
        check("lut_out", 32'(lut_out), 32'(m_out));
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, $urandom, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
    endtask

    // Offer nbeats words from ld_words; cfg_last on beat last_beat (-1: never).
    task automatic feed(input int nbeats, input int last_beat, input int gap_pct);
        for (int b = 0; b < nbeats; b++) begin
            for (int g = 0; g < 4 && int'($urandom_range(0, 99)) < gap_pct; g++) idle_cycle();
            cycle(1'b0, 1'b1, ld_words[b % NW], 1'(b == last_beat),
                  1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        end
    endtask

    task automatic load(input string name, input int nbeats, input int last_beat, input int gap_pct);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
        feed(nbeats, last_beat, gap_pct);
        idle_cycle();
        $display("load %s beats=%0d last=%0d err=%0b done_model_table_valid=%0b",
                 name, nbeats, last_beat, cfg_err, m_valid);
    endtask

    task automatic lookup(input logic [7:0] a);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, a, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
        $display("lookup %02h -> valid=%0b out=%0b", a, m_out_valid, lut_out);
    endtask

    task automatic sweep(input string name);
        for (int a = 0; a < 256; a++) cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'(a), 1'b0);
        idle_cycle();
        $display("sweep %s of 256 addresses", name);
    endtask

    task automatic fill(input int kind);
        for (int w = 0; w < NW; w++) begin
            for (int k = 0; k < EPW; k++) begin
                logic [7:0] aa;
                aa = 8'(w * EPW + k);
                case (kind)
                    0: ld_words[w][k] = aa[5] & ~aa[4];
                    1: ld_words[w][k] = 1'b1;
                    2: ld_words[w][k] = 1'b0;
                    default: ld_words[w][k] = 1'($urandom_range(0, 1));
                endcase
            end
        end
    endtask

    initial begin
        rst = 1'b1; cfg_start = 0; cfg_valid = 0; cfg_data = 0; cfg_last = 0;
        lut_in_valid = 0; lut_in = 0;
        @(posedge clk); #1;
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b1);

        // 1: lookup before any load is invalid; pattern load and directed lookups
        lookup(8'h20);
        fill(0);
        load("pattern", NW, NW - 1, 30);
        lookup(8'h20); lookup(8'h10); lookup(8'hA5); lookup(8'hFF);

        // 2: early cfg_last, then recovery
        fill(3);
        load("early_last", 5, 4, 20);
        lookup(8'h33);
        fill(3);
        load("recover", NW, NW - 1, 20);
        for (int i = 0; i < 16; i++) lookup(8'($urandom));

        // 3: missing cfg_last, a ninth beat is refused
        load("no_last", NW, -1, 0);
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 8'h01, 1'b0);
        idle_cycle();

        // 4: gappy all-ones then all-zeros loads with full sweeps
        fill(1); load("ones", NW, NW - 1, 50); sweep("ones");
        fill(2); load("zeros", NW, NW - 1, 50); sweep("zeros");

        // 5a: start colliding with a beat mid-load restarts the word count
        fill(3);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
        feed(3, -1, 0);
        cycle(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 8'h00, 1'b0);
        fill(3);
        feed(NW, NW - 1, 25);
        idle_cycle();
        $display("load restart_mid_load table_valid=%0b", m_valid);
        for (int i = 0; i < 16; i++) lookup(8'($urandom));

        // 5b: start in READY with a concurrent lookup returns the old entry
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'h5A, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 8'hA5, 1'b0);
        $display("start_in_ready lookup 5a served from old table");
        fill(3);
        feed(NW, NW - 1, 10);
        idle_cycle();

        // 6: reset after beat 3 discards the partial table
        fill(3);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b0);
        feed(3, -1, 0);
        cycle(1'b0, 1'b1, ld_words[3], 1'b0, 1'b0, 8'h00, 1'b1);
        lookup(8'h42);
        cycle(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 8'h00, 1'b0);
        $display("reset_mid_load table_valid=%0b", m_valid);

        // Random reloads and lookups
        for (int r = 0; r < 4; r++) begin
            fill(3);
            load("random", NW, NW - 1, 40);
            for (int i = 0; i < 24; i++) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
